wb_stage: RTL and testbench

//  Registered, parametrised write-back stage between the MEM stage and the register file.

---
 rtl/wb_stage.sv | 188 ++++++++++++++++++
 tb/tb_wb_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: selects PC+4 / ALU / extended load data and issues a 1-cycle rf write.
// Latency 1 cycle from accept (or from late mem_rvalid); optional forwarding port under WB_FWD_EN.
// Backpressure: in_ready drops while a load waits for memory data and during reset.
module wb_stage #(
    parameter int XLEN    = 32,
    parameter int PC_W    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_wdsel,
    input  logic               in_we,
    input  logic [RADDR_W-1:0] in_waddr,
    input  logic [2:0]         in_funct3,
    input  logic [XLEN-1:0]    in_alu_res,
    input  logic [PC_W-1:0]    in_pc_plus_4,
    input  logic               mem_rvalid,
    input  logic [XLEN-1:0]    mem_rdata,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               wb_err
`ifdef WB_FWD_EN
    ,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_addr,
    output logic [XLEN-1:0]    fwd_data
`endif
);

    localparam logic [1:0] WD_PC   = 2'b00;
    localparam logic [1:0] WD_ALU  = 2'b01;
    localparam logic [1:0] WD_LOAD = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t             state, nxt_state;
    logic               accept;

    logic               lat_we;
    logic [RADDR_W-1:0] lat_waddr;
    logic [2:0]         lat_f3;
    logic [1:0]         lat_off;

    logic               ld_we;
    logic [RADDR_W-1:0] ld_waddr;
    logic [2:0]         ld_f3;
    logic [1:0]         ld_off;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic               ld_ok;
    logic [XLEN-1:0]    ld_data;

    logic               ld_fin;
    logic               latch_ld;
    logic               wr_en;
    logic               wr_err;
    logic [RADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]    wr_data;

    assign in_ready = (state == IDLE) && rst_n;
    assign accept   = in_valid && in_ready;

    // A load completes either in its accept cycle or later from the latched request.
    assign ld_we    = (state == WAIT_MEM) ? lat_we    : in_we;
    assign ld_waddr = (state == WAIT_MEM) ? lat_waddr : in_waddr;
    assign ld_f3    = (state == WAIT_MEM) ? lat_f3    : in_funct3;
    assign ld_off   = (state == WAIT_MEM) ? lat_off   : in_alu_res[1:0];

    always_comb begin
        ld_byte = mem_rdata[{ld_off, 3'b000} +: 8];
        ld_half = mem_rdata[{ld_off[1], 4'b0000} +: 16];
        ld_ok   = 1'b1;
        ld_data = '0;
        case (ld_f3)
            F3_LB:  ld_data = XLEN'($signed(ld_byte));
            F3_LBU: ld_data = XLEN'(ld_byte);
            F3_LH: begin
                ld_ok   = !ld_off[0];
                ld_data = XLEN'($signed(ld_half));
            end
            F3_LHU: begin
                ld_ok   = !ld_off[0];
                ld_data = XLEN'(ld_half);
            end
            F3_LW: begin
                ld_ok   = (ld_off == 2'b00);
                ld_data = XLEN'($signed(mem_rdata[31:0]));
            end
            default: ld_ok = 1'b0;
        endcase
    end

    always_comb begin
        nxt_state = state;
        ld_fin    = 1'b0;
        latch_ld  = 1'b0;
        wr_en     = 1'b0;
        wr_err    = 1'b0;
        wr_addr   = rf_waddr;
        wr_data   = rf_wdata;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (in_wdsel)
                        WD_PC: begin
                            wr_addr = in_waddr;
                            wr_data = XLEN'(in_pc_plus_4);
                            wr_en   = in_we && (in_waddr != '0);
                        end
                        WD_ALU: begin
                            wr_addr = in_waddr;
                            wr_data = in_alu_res;
                            wr_en   = in_we && (in_waddr != '0);
                        end
                        WD_LOAD: begin
                            if (mem_rvalid) begin
                                ld_fin = 1'b1;
                            end else begin
                                latch_ld  = 1'b1;
                                nxt_state = WAIT_MEM;
                            end
                        end
                        default: wr_err = 1'b1;
                    endcase
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    ld_fin    = 1'b1;
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
        // Illegal or misaligned loads drop the write and leave the outputs holding.
        if (ld_fin) begin
            if (ld_ok) begin
                wr_addr = ld_waddr;
                wr_data = ld_data;
                wr_en   = ld_we && (ld_waddr != '0);
            end else begin
                wr_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            wb_err    <= 1'b0;
            lat_we    <= 1'b0;
            lat_waddr <= '0;
            lat_f3    <= '0;
            lat_off   <= '0;
        end else begin
            state    <= nxt_state;
            rf_we    <= wr_en;
            rf_waddr <= wr_addr;
            rf_wdata <= wr_data;
            wb_err   <= wr_err;
            if (latch_ld) begin
                lat_we    <= in_we;
                lat_waddr <= in_waddr;
                lat_f3    <= in_funct3;
                lat_off   <= in_alu_res[1:0];
            end
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid = wr_en && rst_n;
    assign fwd_addr  = wr_addr;
    assign fwd_data  = wr_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cases with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the write-back rules.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_wdsel;
    logic        in_we;
    logic [4:0]  in_waddr;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_res;
    logic [31:0] in_pc_plus_4;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_err;

    int n_cmp = 0;
    int n_bad = 0;

    wb_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_wdsel(in_wdsel), .in_we(in_we), .in_waddr(in_waddr), .in_funct3(in_funct3),
        .in_alu_res(in_alu_res), .in_pc_plus_4(in_pc_plus_4), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]  wdsel;
        logic        we;
        logic [4:0]  waddr;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] pc;
    } req_t;

    req_t        pend_q[$];
    logic        exp_we   = 1'b0;
    logic        exp_err  = 1'b0;
    logic [4:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;

    function automatic void load_calc(input logic [2:0] f3, input logic [1:0] off,
                                      input logic [31:0] rd, output logic ok,
                                      output logic [31:0] v);
        logic [31:0] b, h;
        b  = (rd >> (8 * off)) & 32'h0000_00FF;
        h  = (rd >> (8 * off)) & 32'h0000_FFFF;
        ok = 1'b1;
        v  = 32'h0;
        case (f3)
            3'd0: v = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd4: v = b;
            3'd1: begin ok = (off % 2 == 0); v = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h; end
            3'd5: begin ok = (off % 2 == 0); v = h; end
            3'd2: begin ok = (off == 0); v = rd; end
            default: ok = 1'b0;
        endcase
    endfunction

    function automatic void complete(input req_t r, input logic [31:0] rd);
        logic        ok;
        logic [31:0] v;
        ok = 1'b1;
        v  = 32'h0;
        case (r.wdsel)
            2'd0: v = r.pc;
            2'd1: v = r.alu;
            2'd2: load_calc(r.f3, r.off, rd, ok, v);
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            exp_err = 1'b1;
        end else begin
            exp_addr = r.waddr;
            exp_data = v;
            exp_we   = r.we && (r.waddr != 5'd0);
        end
    endfunction

    always @(posedge clk) begin
        req_t r;
        if (!rst_n) begin
            pend_q.delete();
            exp_we = 0; exp_err = 0; exp_addr = '0; exp_data = '0;
        end else begin
            exp_we  = 0;
            exp_err = 0;
            if (pend_q.size() != 0) begin
                if (mem_rvalid) complete(pend_q.pop_front(), mem_rdata);
            end else if (in_valid) begin
                r.wdsel = in_wdsel; r.we = in_we; r.waddr = in_waddr; r.f3 = in_funct3;
                r.off = in_alu_res[1:0]; r.alu = in_alu_res; r.pc = in_pc_plus_4;
                if (r.wdsel == 2'd2 && !mem_rvalid) pend_q.push_back(r);
                else complete(r, mem_rdata);
            end
        end
    end

    // Single compare process against the model, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(rst_n && pend_q.size() == 0));
        chk("rf_we",    32'(rf_we),    32'(exp_we));
        chk("wb_err",   32'(wb_err),   32'(exp_err));
        chk("rf_waddr", 32'(rf_waddr), 32'(exp_addr));
        chk("rf_wdata", rf_wdata,      exp_data);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [1:0] ws, input logic we, input logic [4:0] wa,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc,
                         input logic rv, input logic [31:0] rd);
        in_valid = v; in_wdsel = ws; in_we = we; in_waddr = wa; in_funct3 = f3;
        in_alu_res = alu; in_pc_plus_4 = pc; mem_rvalid = rv; mem_rdata = rd;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic rv, input logic [31:0] rd);
        drive(1'b0, 2'd0, 1'b0, 5'd0, 3'd0, 32'h0, 32'h0, rv, rd);
    endtask

    initial begin
        rst_n = 1'b0;
        // 1: reset held with a request present
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd1, 1'b1, 5'd7, 3'd0, 32'hDEAD_BEEF, 32'h4, 1'b1, 32'h1);
            chk("rst_ready", 32'(in_ready), 32'd0);
        end
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_err", 32'(wb_err), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        rst_n = 1'b1;

        // 2: ALU then PC+4 back to back
        drive(1'b1, 2'd1, 1'b1, 5'd7, 3'd0, 32'h1234_5678, 32'h0, 1'b0, 32'h0);
        chk("alu_we", 32'(rf_we), 32'd1);
        chk("alu_data", rf_wdata, 32'h1234_5678);
        chk("alu_addr", 32'(rf_waddr), 32'd7);
        drive(1'b1, 2'd0, 1'b1, 5'd1, 3'd0, 32'h0, 32'h40, 1'b0, 32'h0);
        chk("pc_we", 32'(rf_we), 32'd1);
        chk("pc_data", rf_wdata, 32'h0000_0040);
        idle(1'b0, 32'h0);
        chk("idle_we", 32'(rf_we), 32'd0);

        // 3: delayed loads; a request is held on in_valid while stalled
        drive(1'b1, 2'd2, 1'b1, 5'd3, 3'd0, 32'h0000_1003, 32'h0, 1'b0, 32'h0);
        chk("lb_stall0", 32'(in_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'd1, 1'b1, 5'd9, 3'd0, 32'h5555, 32'h0, 1'b0, 32'h0);
            chk("lb_stall", 32'(in_ready), 32'd0);
            chk("lb_nowe", 32'(rf_we), 32'd0);
        end
        drive(1'b1, 2'd1, 1'b1, 5'd9, 3'd0, 32'h5555, 32'h0, 1'b1, 32'h80FF_0000);
        chk("lb_we", 32'(rf_we), 32'd1);
        chk("lb_data", rf_wdata, 32'hFFFF_FF80);
        chk("lb_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 2'd2, 1'b1, 5'd4, 3'd4, 32'h0000_0003, 32'h0, 1'b0, 32'h0);
        idle(1'b0, 32'h0);
        idle(1'b1, 32'h80FF_0000);
        chk("lbu_data", rf_wdata, 32'h0000_0080);
        drive(1'b1, 2'd2, 1'b1, 5'd4, 3'd5, 32'h0000_0002, 32'h0, 1'b1, 32'h80FF_0000);
        chk("lhu_we", 32'(rf_we), 32'd1);
        chk("lhu_data", rf_wdata, 32'h0000_80FF);

        // 4: error cases
        drive(1'b1, 2'd2, 1'b1, 5'd6, 3'd1, 32'h0000_0001, 32'h0, 1'b1, 32'h1234_5678);
        chk("lh_mis_we", 32'(rf_we), 32'd0);
        chk("lh_mis_err", 32'(wb_err), 32'd1);
        drive(1'b1, 2'd3, 1'b1, 5'd6, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("rsv_we", 32'(rf_we), 32'd0);
        chk("rsv_err", 32'(wb_err), 32'd1);
        idle(1'b0, 32'h0);
        chk("err_clear", 32'(wb_err), 32'd0);

        // 5: x0 and we gating
        drive(1'b1, 2'd1, 1'b1, 5'd0, 3'd0, 32'hCAFE_0001, 32'h0, 1'b0, 32'h0);
        chk("x0_we", 32'(rf_we), 32'd0);
        chk("x0_data", rf_wdata, 32'hCAFE_0001);
        drive(1'b1, 2'd1, 1'b0, 5'd5, 3'd0, 32'hCAFE_0002, 32'h0, 1'b0, 32'h0);
        chk("nowe_we", 32'(rf_we), 32'd0);
        chk("nowe_addr", 32'(rf_waddr), 32'd5);

        // 6: reset while waiting for memory
        drive(1'b1, 2'd2, 1'b1, 5'd8, 3'd2, 32'h0000_0100, 32'h0, 1'b0, 32'h0);
        rst_n = 1'b0;
        idle(1'b0, 32'h0);
        rst_n = 1'b1;
        idle(1'b1, 32'hAAAA_BBBB);
        chk("rstwait_we", 32'(rf_we), 32'd0);
        chk("rstwait_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 2'd1, 1'b1, 5'd3, 3'd0, 32'h0BAD_F00D, 32'h0, 1'b0, 32'h0);
        chk("after_rst_we", 32'(rf_we), 32'd1);
        chk("after_rst_data", rf_wdata, 32'h0BAD_F00D);

        // Random traffic, checked by the per-cycle compare process
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), $urandom_range(0, 7) != 0,
                  5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom_range(0, 9) < 4, $urandom);
        end
        rst_n = 1'b1;
        idle(1'b0, 32'h0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
